pr_div_scheduler: RTL and testbench
===================================

// Module: pr_div_scheduler
// PURPOSE
//   Shares one iterative page-rank divider (quotient = page_rank / out_deg) between
//   N_REQ node-update requesters. Round-robin arbitration, one division in flight,
//   start/done sequencing of the divider, zero-out-degree bypass and optional watchdog.
//   Sits between the per-node rank update lanes and the single divider instance.
// PARAMETERS
//   N_REQ    4    number of requesters (2..16)
//   W        32   operand/quotient width
//   IDW      2    requester id width, >= clog2(N_REQ)
//   TIMEOUT  0    max cycles in WAIT before abort; 0 = watchdog disabled
// PORTS
//   clk           in   1        clock, rising edge
//   reset         in   1        asynchronous active-low reset
//   req_valid     in   N_REQ    requester i has operands pending
//   req_ready     out  N_REQ    one-hot accept pulse, 1 cycle
//   req_rank      in   N_REQ*W  page_rank of requester i, bits [i*W +: W]
//   req_deg       in   N_REQ*W  out_deg of requester i, bits [i*W +: W]
//   div_start     out  1        1-cycle start pulse to divider
//   div_dividend  out  W        page_rank to divider, stable ISSUE..WAIT
//   div_divisor   out  W        out_deg to divider, stable ISSUE..WAIT
//   div_done      in   1        divider done (may be level/sticky)
//   div_quotient  in   W        divider result, valid with div_done rise
//   rsp_valid     out  1        result available
//   rsp_ready     in   1        consumer accepts result
//   rsp_id        out  IDW      requester id of result
//   rsp_quotient  out  W        quotient
//   rsp_dz        out  1        out_deg was 0, divider not used, quotient 0
//   rsp_to        out  1        watchdog abort, quotient all-ones
//   busy          out  1        state != IDLE
// BEHAVIOUR
//   Reset (async, reset=0): state IDLE, rr_ptr 0, all outputs 0, operand/result regs 0.
//   FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; IDLE -> RESP directly for out_deg==0.
//   IDLE: if any req_valid, grant first valid index at or after rr_ptr, wrapping mod N_REQ;
//     req_ready[sel]=1 that cycle only, latch rank/deg/id. deg==0: quotient 0, rsp_dz=1,
//     -> RESP. Else -> ISSUE. No req_valid: stay, req_ready all 0.
//   ISSUE: div_start=1 for exactly this cycle -> WAIT.
//   WAIT: done_q registers div_done every cycle; completion = div_done & ~done_q (rising
//     edge), so a done left high from a previous op is never taken. On completion latch
//     div_quotient -> RESP. TIMEOUT>0: cycle counter from WAIT entry; reaching TIMEOUT
//     without completion -> RESP, quotient {W{1'b1}}, rsp_to=1.
//   RESP: rsp_valid=1, rsp_id/quotient/dz/to held stable until rsp_ready. Cycle with
//     rsp_valid&rsp_ready: -> IDLE, rr_ptr = (id+1) mod N_REQ, rsp_* flags clear next cycle.
//   Latency accept->rsp_valid: 1 cycle (dz), else 2 + divider cycles to done rise.
//   Min gap between accepts: 1 idle cycle (response handshake to next grant).
//   req_valid dropping mid-op: no effect; operands already latched.
//   div_done outside WAIT ignored (only done_q updates). rsp_ready outside RESP ignored.
//   Reset mid-op: immediate return to IDLE, in-flight result discarded, div_start 0.
//   Fairness: a continuously valid requester is granted within N_REQ grants.
// TESTING
//   1 single op: req0 rank=100 deg=7, divider done 5 cyc after start -> one req_ready[0]
//     pulse, one div_start, rsp id=0 q=14 dz=0 to=0.
//   2 round robin: all 4 valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1.
//   3 zero degree: req2 rank=500 deg=0 -> no div_start, rsp id=2 q=0 dz=1, 1 cycle latency.
//   4 backpressure/sticky done: rsp_ready=0 for 10 cyc, div_done kept high -> rsp data
//     stable, next op waits for a fresh done rise, not the stale level.
//   5 watchdog TIMEOUT=8: divider never done -> rsp q=32'hFFFFFFFF to=1 after 8 WAIT cycles.
//   6 reset asserted in WAIT -> all outputs 0 at once; late div_done after release ignored.

Source files
------------

// File: rtl/pr_div_scheduler.sv
// pr_div_scheduler: round-robin front end that shares one iterative
// page_rank / out_deg divider between N_REQ node-update lanes. Handles the
// start/done handshake of the divider, bypasses it for zero out-degree and
// optionally aborts a stuck division with an all-ones quotient.
module pr_div_scheduler #(
    parameter int N_REQ   = 4,
    parameter int W       = 32,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_rank,
    input  logic [N_REQ*W-1:0] req_deg,
    output logic               div_start,
    output logic [W-1:0]       div_dividend,
    output logic [W-1:0]       div_divisor,
    input  logic               div_done,
    input  logic [W-1:0]       div_quotient,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [W-1:0]       rsp_quotient,
    output logic               rsp_dz,
    output logic               rsp_to,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] rr_ptr;
    logic           done_q;
    logic [31:0]    wait_cnt;

    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [IDW:0]   grant_sum;
    logic [W-1:0]   grant_rank;
    logic [W-1:0]   grant_deg;
    logic [2*N_REQ-1:0] rot_valid;
    logic           done_rise;
    logic           wd_expired;

    // Only a rising edge of done counts, so a level left high by the
    // previous division can never complete the current one.
    assign done_rise  = div_done & ~done_q;
    assign wd_expired = (TIMEOUT != 0) && (wait_cnt == 32'(TIMEOUT - 1));

    assign div_start  = (state == S_ISSUE);
    assign rsp_valid  = (state == S_RESP);
    assign busy       = (state != S_IDLE);

    // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        grant_found = 1'b0;
        grant_sum   = '0;
        grant_idx   = '0;
        grant_rank  = '0;
        grant_deg   = '0;
        rot_valid   = {req_valid, req_valid} >> rr_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            if (!grant_found && rot_valid[k]) begin
                grant_found = 1'b1;
                grant_sum   = {1'b0, rr_ptr} + (IDW+1)'(k);
            end
        end
        if (grant_sum >= (IDW+1)'(N_REQ))
            grant_idx = IDW'(grant_sum - (IDW+1)'(N_REQ));
        else
            grant_idx = IDW'(grant_sum);
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                grant_rank = req_rank[i*W +: W];
                grant_deg  = req_deg[i*W +: W];
            end
        end
    end

    // One-hot accept pulse, only in IDLE and never while reset is held.
    always_comb begin
        req_ready = '0;
        if (reset && state == S_IDLE && grant_found)
            req_ready = N_REQ'(1) << grant_idx;
    end

    // Next-state logic of the IDLE/ISSUE/WAIT/RESP sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (grant_found)
                    state_nxt = (grant_deg == '0) ? S_RESP : S_ISSUE;
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (done_rise || wd_expired)
                    state_nxt = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Operand/result registers, watchdog counter and round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_q       <= 1'b0;
            wait_cnt     <= '0;
            rr_ptr       <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
            rsp_id       <= '0;
            rsp_quotient <= '0;
            rsp_dz       <= 1'b0;
            rsp_to       <= 1'b0;
        end else begin
            done_q <= div_done;
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        div_dividend <= grant_rank;
                        div_divisor  <= grant_deg;
                        rsp_id       <= grant_idx;
                        rsp_quotient <= '0;
                        rsp_dz       <= (grant_deg == '0);
                        rsp_to       <= 1'b0;
                    end
                end
                S_ISSUE: wait_cnt <= '0;
                S_WAIT: begin
                    if (done_rise) begin
                        rsp_quotient <= div_quotient;
                    end else if (wd_expired) begin
                        rsp_quotient <= '1;
                        rsp_to       <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rr_ptr <= (rsp_id == IDW'(N_REQ - 1)) ? '0 : rsp_id + 1'b1;
                        rsp_dz <= 1'b0;
                        rsp_to <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pr_div_scheduler.sv
// Directed bench for pr_div_scheduler: a behavioural divider answers each
// start after five cycles (pulsed, sticky or never), and each scenario task
// compares DUT outputs against hand-computed values.
module tb_pr_div_scheduler;

    localparam int N_REQ = 4;
    localparam int W     = 32;
    localparam int IDW   = 2;

    typedef enum int { M_PULSE, M_STICKY, M_NEVER } div_mode_t;

    logic               clk = 1'b0;
    logic               reset;
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ*W-1:0] req_rank;
    logic [N_REQ*W-1:0] req_deg;
    logic               div_start;
    logic [W-1:0]       div_dividend;
    logic [W-1:0]       div_divisor;
    logic               div_done;
    logic [W-1:0]       div_quotient;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [W-1:0]       rsp_quotient;
    logic               rsp_dz;
    logic               rsp_to;
    logic               busy;

    int vectors     = 0;
    int miscompares = 0;

    div_mode_t div_mode = M_PULSE;
    int        n_start  = 0;
    int        grant_q[$];
    int        rsp_id_q[$];
    logic [W-1:0] rsp_qt_q[$];

    pr_div_scheduler #(.N_REQ(N_REQ), .W(W), .IDW(IDW), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rank(req_rank), .req_deg(req_deg),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_done(div_done), .div_quotient(div_quotient),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_quotient(rsp_quotient), .rsp_dz(rsp_dz), .rsp_to(rsp_to), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural divider: raises done 5 cycles after start.
    initial begin
        int           cnt;
        bit           pending;
        logic [W-1:0] q;
        cnt = 0; pending = 0; q = '0;
        div_done = 1'b0; div_quotient = '0;
        forever begin
            @(negedge clk);
            if (pending) begin
                cnt--;
                if (div_mode == M_STICKY && cnt == 2) div_done = 1'b0;
                if (cnt == 0) begin
                    div_done = 1'b1; div_quotient = q; pending = 0;
                end
            end else if (div_done && div_mode == M_PULSE) begin
                div_done = 1'b0;
            end
            if (div_start && div_mode != M_NEVER) begin
                pending = 1; cnt = 5;
                q = div_dividend / div_divisor;
                if (div_mode == M_PULSE) div_done = 1'b0;
            end
        end
    end

    // Event monitor, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk); #3;
            if (div_start) n_start++;
            for (int i = 0; i < N_REQ; i++) if (req_ready[i]) grant_q.push_back(i);
            if (rsp_valid && rsp_ready) begin
                rsp_id_q.push_back(int'(rsp_id));
                rsp_qt_q.push_back(rsp_quotient);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, want finish");
        $fatal(1, "timeout");
    end

    task automatic set_op(input int i, input logic [W-1:0] rank, input logic [W-1:0] deg);
        req_rank[i*W +: W] = rank;
        req_deg[i*W +: W]  = deg;
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b0;
        @(negedge clk); @(negedge clk); reset = 1'b1;
    endtask

    // Present one request for one cycle; returns the accept vector seen.
    // Leaves time at the sample point of the cycle after the accept.
    task automatic issue(input int i, input logic [W-1:0] rank, input logic [W-1:0] deg,
                         output logic [N_REQ-1:0] rdy);
        @(negedge clk);
        set_op(i, rank, deg);
        req_valid = N_REQ'(1) << i;
        #4 rdy = req_ready;
        @(negedge clk);
        req_valid = '0;
        #4;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk); #4; lat++;
        end
    endtask

    task automatic finish_rsp();
        @(negedge clk); rsp_ready = 1'b1;
        @(negedge clk); rsp_ready = 1'b0;
        #4;
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = 4'hF; rsp_ready = 1'b1;
        req_rank = '0; req_deg = '0;
        #12;
        vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
        vectors++; if (div_start !== 1'b0) begin miscompares++; $display("FAIL rst_start: got %b want 0", div_start); end
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
        vectors++; if (rsp_quotient !== 32'd0) begin miscompares++; $display("FAIL rst_quotient: got %0h want 0", rsp_quotient); end
        req_valid = '0; rsp_ready = 1'b0;
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_single_op();
        logic [N_REQ-1:0] rdy;
        int lat;
        n_start = 0; grant_q.delete();
        issue(0, 32'd100, 32'd7, rdy);
        vectors++; if (rdy !== 4'b0001) begin miscompares++; $display("FAIL t1_ready: got %b want 0001", rdy); end
        vectors++; if (div_start !== 1'b1) begin miscompares++; $display("FAIL t1_start: got %b want 1", div_start); end
        vectors++; if (div_dividend !== 32'd100) begin miscompares++; $display("FAIL t1_dividend: got %0d want 100", div_dividend); end
        vectors++; if (div_divisor !== 32'd7) begin miscompares++; $display("FAIL t1_divisor: got %0d want 7", div_divisor); end
        wait_rsp(lat);
        vectors++; if (lat !== 7) begin miscompares++; $display("FAIL t1_latency: got %0d want 7", lat); end
        vectors++; if (rsp_id !== 2'd0) begin miscompares++; $display("FAIL t1_id: got %0d want 0", rsp_id); end
        vectors++; if (rsp_quotient !== 32'd14) begin miscompares++; $display("FAIL t1_quotient: got %0d want 14", rsp_quotient); end
        vectors++; if (rsp_dz !== 1'b0 || rsp_to !== 1'b0) begin miscompares++; $display("FAIL t1_flags: got dz=%b to=%b want 0 0", rsp_dz, rsp_to); end
        finish_rsp();
        vectors++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL t1_idle: got valid=%b busy=%b want 0 0", rsp_valid, busy); end
        vectors++; if (n_start !== 1) begin miscompares++; $display("FAIL t1_start_count: got %0d want 1", n_start); end
        vectors++; if (grant_q.size() !== 1) begin miscompares++; $display("FAIL t1_grant_count: got %0d want 1", grant_q.size()); end
    endtask

    task automatic test_round_robin();
        int exp_grant[6] = '{0, 1, 2, 3, 0, 1};
        int exp_q[4]     = '{60, 45, 40, 37};
        int cyc;
        int got;
        do_reset();
        set_op(0, 32'd60, 32'd1);  set_op(1, 32'd90, 32'd2);
        set_op(2, 32'd120, 32'd3); set_op(3, 32'd150, 32'd4);
        grant_q.delete(); rsp_id_q.delete(); rsp_qt_q.delete();
        @(negedge clk); rsp_ready = 1'b1; req_valid = 4'hF;
        cyc = 0;
        while (grant_q.size() < 6 && cyc < 200) begin @(negedge clk); #4; cyc++; end
        @(negedge clk); req_valid = '0;
        cyc = 0;
        #4 while (busy && cyc < 40) begin @(negedge clk); #4; cyc++; end
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            got = (i < grant_q.size()) ? grant_q[i] : -1;
            vectors++; if (got !== exp_grant[i]) begin miscompares++; $display("FAIL t2_grant%0d: got %0d want %0d", i, got, exp_grant[i]); end
        end
        vectors++; if (rsp_id_q.size() !== 6) begin miscompares++; $display("FAIL t2_rsp_count: got %0d want 6", rsp_id_q.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < rsp_qt_q.size()) ? int'(rsp_qt_q[i]) : -1;
            vectors++; if (got !== exp_q[i]) begin miscompares++; $display("FAIL t2_q%0d: got %0d want %0d", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_zero_degree();
        logic [N_REQ-1:0] rdy;
        n_start = 0;
        issue(2, 32'd500, 32'd0, rdy);
        vectors++; if (rdy !== 4'b0100) begin miscompares++; $display("FAIL t3_ready: got %b want 0100", rdy); end
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL t3_latency: got valid=%b want 1 after one cycle", rsp_valid); end
        vectors++; if (rsp_id !== 2'd2) begin miscompares++; $display("FAIL t3_id: got %0d want 2", rsp_id); end
        vectors++; if (rsp_quotient !== 32'd0) begin miscompares++; $display("FAIL t3_quotient: got %0d want 0", rsp_quotient); end
        vectors++; if (rsp_dz !== 1'b1 || rsp_to !== 1'b0) begin miscompares++; $display("FAIL t3_flags: got dz=%b to=%b want 1 0", rsp_dz, rsp_to); end
        finish_rsp();
        vectors++; if (n_start !== 0) begin miscompares++; $display("FAIL t3_no_start: got %0d starts want 0", n_start); end
        vectors++; if (rsp_dz !== 1'b0) begin miscompares++; $display("FAIL t3_dz_clear: got %b want 0", rsp_dz); end
    endtask

    task automatic test_backpressure_sticky();
        logic [N_REQ-1:0] rdy;
        int lat;
        int bad;
        div_mode = M_STICKY;
        issue(1, 32'd1000, 32'd9, rdy);
        wait_rsp(lat);
        vectors++; if (lat !== 7) begin miscompares++; $display("FAIL t4_latency_a: got %0d want 7", lat); end
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #4;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_quotient !== 32'd111 || rsp_dz !== 1'b0) bad++;
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL t4_hold: got %0d unstable cycles want 0", bad); end
        vectors++; if (div_done !== 1'b1) begin miscompares++; $display("FAIL t4_done_level: got %b want 1", div_done); end
        finish_rsp();
        issue(3, 32'd81, 32'd4, rdy);
        wait_rsp(lat);
        vectors++; if (lat !== 7) begin miscompares++; $display("FAIL t4_latency_b: got %0d want 7", lat); end
        vectors++; if (rsp_id !== 2'd3) begin miscompares++; $display("FAIL t4_id_b: got %0d want 3", rsp_id); end
        vectors++; if (rsp_quotient !== 32'd20) begin miscompares++; $display("FAIL t4_quotient_b: got %0d want 20", rsp_quotient); end
        div_mode = M_PULSE;
        finish_rsp();
        @(negedge clk);
    endtask

    task automatic test_watchdog();
        logic [N_REQ-1:0] rdy;
        int lat;
        div_mode = M_NEVER;
        n_start = 0;
        issue(0, 32'd5, 32'd1, rdy);
        wait_rsp(lat);
        vectors++; if (lat !== 10) begin miscompares++; $display("FAIL t5_latency: got %0d want 10", lat); end
        vectors++; if (rsp_quotient !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL t5_quotient: got %0h want ffffffff", rsp_quotient); end
        vectors++; if (rsp_to !== 1'b1 || rsp_dz !== 1'b0) begin miscompares++; $display("FAIL t5_flags: got to=%b dz=%b want 1 0", rsp_to, rsp_dz); end
        vectors++; if (rsp_id !== 2'd0) begin miscompares++; $display("FAIL t5_id: got %0d want 0", rsp_id); end
        finish_rsp();
        vectors++; if (rsp_to !== 1'b0) begin miscompares++; $display("FAIL t5_to_clear: got %b want 0", rsp_to); end
        vectors++; if (n_start !== 1) begin miscompares++; $display("FAIL t5_start_count: got %0d want 1", n_start); end
        div_mode = M_PULSE;
    endtask

    task automatic test_reset_mid_op();
        logic [N_REQ-1:0] rdy;
        int lat;
        int bad;
        issue(2, 32'd30, 32'd3, rdy);
        @(negedge clk); #4;
        @(negedge clk); #4;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL t6_busy_wait: got %b want 1", busy); end
        @(negedge clk); reset = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0 || div_start !== 1'b0 || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL t6_rst_ctrl: got busy=%b start=%b valid=%b want 0 0 0", busy, div_start, rsp_valid); end
        vectors++; if (div_dividend !== 32'd0 || div_divisor !== 32'd0) begin miscompares++; $display("FAIL t6_rst_operands: got %0d/%0d want 0/0", div_dividend, div_divisor); end
        @(negedge clk); @(negedge clk); reset = 1'b1;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #4;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL t6_late_done: got %0d active cycles want 0", bad); end
        issue(1, 32'd64, 32'd8, rdy);
        vectors++; if (rdy !== 4'b0010) begin miscompares++; $display("FAIL t6_ready_after: got %b want 0010", rdy); end
        wait_rsp(lat);
        vectors++; if (lat !== 7 || rsp_quotient !== 32'd8) begin miscompares++; $display("FAIL t6_recover: got lat=%0d q=%0d want 7 8", lat, rsp_quotient); end
        finish_rsp();
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_round_robin();
        test_zero_degree();
        test_backpressure_sticky();
        test_watchdog();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
